k16_tone_gen: RTL and testbench
===============================

// Module: k16_tone_gen
// PURPOSE
//  Memory-mapped square-wave tone sequencer on the K16 I/O bus. It is the sound source
//  for the front-panel I/O block's speaker pin.
//  The CPU stages a half-period, then writes a duration. That write queues one note into
//  a small FIFO, and the notes are played back-to-back without CPU attention.
//  Registers use the same addr/din/write_en/dout convention as the front-panel I/O block.
// PARAMETERS
//  CLK_HZ      25000000  system clock frequency
//  TICK_HZ     1000      duration tick rate; TICK_DIV = CLK_HZ/TICK_HZ clocks per tick
//  PRESCALE    16        clocks per half-period unit
//  FIFO_DEPTH  4         note queue entries (power of 2, >=2)
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  reset     in   1   asynchronous, active-high reset
//  addr      in   2   register select
//  din       in   16  write data
//  write_en  in   1   write strobe, sampled on posedge clk
//  dout      out  16  registered read data
//  sound     out  1   square-wave speaker output
//  busy      out  1   1 when state != IDLE or FIFO not empty
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, period_stage=0, overflow=0, dout=0, sound=0, busy=0.
//  Register map. Read latency is 1 cycle; dout updates every cycle from addr.
//   0 PERIOD: write sets period_stage (half-period in PRESCALE units); read returns period_stage.
//   1 DURATION: write pushes {period_stage, din} as a note (duration in ticks); read returns
//     remaining ticks of the current note, or 0 when IDLE.
//   2 CTRL/STAT:
//     read = {8'b0, count[3:0], overflow, full, empty, playing}, with playing=(state==PLAY).
//     write bit0=1: flush. FIFO is emptied, state goes IDLE, sound=0 next cycle.
//     write bit1=1: clear overflow.
//   3 ID: read 16'h70E5; writes are ignored.
//  FIFO rules:
//   - Push when full is dropped and sets sticky overflow.
//   - Push and pop in the same cycle while full is accepted.
//   - Flush and push in the same cycle: flush wins and the note is discarded.
//   - Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH.
//  FSM:
//   - IDLE: sound=0. If !empty, pop to LOAD.
//   - LOAD (1 cycle): latch period and duration.
//       If duration==0, go to IDLE, or pop again to LOAD if !empty.
//       Otherwise go to PLAY with remaining=duration; tick counter, prescaler and phase cleared.
//   - PLAY: lasts exactly duration*TICK_DIV cycles.
//       The tick counter counts 0..TICK_DIV-1; on wrap, remaining decrements.
//       When remaining reaches 0: pop to LOAD if !empty, else go to IDLE.
//  Tone:
//   - period==0 is a rest: sound=0 for the whole PLAY.
//   - Otherwise sound=1 on the first PLAY cycle, then toggles every period*PRESCALE clocks.
//   - Counters are 16-bit plus prescaler. No overflow is possible.
//  Note gap: exactly one LOAD cycle with sound=0 between consecutive notes.
//  Reset asserted mid-note: immediate return to reset values.
//  Flush mid-note: note aborted on the next edge.
// TESTING (CLK_HZ=1000, TICK_HZ=100 so TICK_DIV=10; PRESCALE=2)
//  1. Reset: after reset release -> sound=0, busy=0, dout=0; read addr 3 -> 16'h70E5 one cycle later.
//  2. Single note: write P=3, D=2 -> LOAD then 20 PLAY cycles.
//     sound pattern 1x6,0x6,1x6,0x2, then IDLE and busy=0.
//  3. Queue: push 5 notes back-to-back while idle-playing (DEPTH=4).
//     -> overflow=1 only if the 5th push finds the FIFO full.
//     -> notes play with 1-cycle gaps. Write bit1 clears overflow.
//  4. Rest/zero: note P=0, D=1 -> 10 cycles sound=0 with playing=1.
//     Note D=0 -> popped, never enters PLAY.
//  5. Flush mid-note: write ctrl=1 during PLAY -> next cycle IDLE, sound=0, empty=1.
//     A simultaneous push is dropped.
//  6. Async reset asserted mid-PLAY between clock edges -> sound=0 and busy=0 before the next edge.

Source files
------------

// File: rtl/k16_tone_gen.sv
// Square-wave tone sequencer on the K16 I/O bus: notes {half-period, duration}
// are queued in a small FIFO and played back-to-back on the speaker pin.
module k16_tone_gen #(
    parameter int CLK_HZ     = 25000000,
    parameter int TICK_HZ    = 1000,
    parameter int PRESCALE   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [15:0] din,
    input  logic        write_en,
    output logic [15:0] dout,
    output logic        sound,
    output logic        busy
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    logic [31:0]   fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, rdPtr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q;
    logic [15:0]   periodStage_q;
    state_t        state_q;
    logic [15:0]   period_q, remaining_q, half_q;
    logic [TW-1:0] tick_q;
    logic [PW-1:0] presc_q;
    logic          sound_q;
    logic [15:0]   dout_q;

    logic        wrPeriod, wrDur, wrCtrl, flush, empty, full;
    logic        tickWrap, noteEnd, pop, pushOk, ovfSet;
    logic [31:0] head;
    logic [3:0]  count4;

    assign wrPeriod = write_en && (addr == 2'd0);
    assign wrDur    = write_en && (addr == 2'd1);
    assign wrCtrl   = write_en && (addr == 2'd2);
    assign flush    = wrCtrl && din[0];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign head     = fifoMem_q[rdPtr_q];
    assign count4   = 4'(count_q);

    assign tickWrap = (tick_q == TW'(TICK_DIV - 1));
    assign noteEnd  = (state_q == PLAY) && tickWrap && (remaining_q == 16'd1);
    // A pop hands the head note to LOAD; flush always wins over both pop and push.
    assign pop    = !flush && !empty &&
                    ((state_q == IDLE) || ((state_q == LOAD) && (remaining_q == 16'd0)) || noteEnd);
    assign pushOk = wrDur && !flush && (!full || pop);
    assign ovfSet = wrDur && !flush && full && !pop;

    always_comb begin
        count_d = count_q;
        if (pushOk && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!pushOk && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk) begin
            fifoMem_q[wrPtr_q] <= {periodStage_q, din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            if (din[1]) begin
                overflow_q <= 1'b0;
            end
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
            if (ovfSet) begin
                overflow_q <= 1'b1;
            end else if (wrCtrl && din[1]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Player: sound toggles whenever prescaler and half-period counter both wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            period_q    <= '0;
            remaining_q <= '0;
            half_q      <= '0;
            tick_q      <= '0;
            presc_q     <= '0;
            sound_q     <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            sound_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sound_q <= 1'b0;
                    if (pop) begin
                        period_q    <= head[31:16];
                        remaining_q <= head[15:0];
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    sound_q <= 1'b0;
                    if (remaining_q == 16'd0) begin
                        if (pop) begin
                            period_q    <= head[31:16];
                            remaining_q <= head[15:0];
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= PLAY;
                        tick_q  <= '0;
                        presc_q <= '0;
                        half_q  <= '0;
                        sound_q <= (period_q != 16'd0);
                    end
                end
                PLAY: begin
                    if (tickWrap) begin
                        tick_q      <= '0;
                        remaining_q <= remaining_q - 16'd1;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                    if (presc_q == PW'(PRESCALE - 1)) begin
                        presc_q <= '0;
                        if (half_q == period_q - 16'd1) begin
                            half_q <= '0;
                            if (period_q != 16'd0) begin
                                sound_q <= ~sound_q;
                            end
                        end else begin
                            half_q <= half_q + 16'd1;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                    if (noteEnd) begin
                        sound_q <= 1'b0;
                        if (pop) begin
                            period_q    <= head[31:16];
                            remaining_q <= head[15:0];
                            state_q     <= LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            periodStage_q <= '0;
            dout_q        <= '0;
        end else begin
            if (wrPeriod) begin
                periodStage_q <= din;
            end
            case (addr)
                2'd0:    dout_q <= periodStage_q;
                2'd1:    dout_q <= (state_q == IDLE) ? 16'd0 : remaining_q;
                2'd2:    dout_q <= {8'h00, count4, overflow_q, full, empty, state_q == PLAY};
                default: dout_q <= 16'h70E5;
            endcase
        end
    end

    assign dout  = dout_q;
    assign sound = sound_q;
    assign busy  = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_k16_tone_gen.sv
// Bench for k16_tone_gen: note batches are predicted from a timeline model
// (pop times, FIFO occupancy, tone phase) and checked by a scoreboard monitor.
module tb_k16_tone_gen;

    localparam int TICK_DIV = 10;
    localparam int PRESC    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [15:0] din;
    logic        write_en;
    logic [15:0] dout;
    logic        sound;
    logic        busy;

    k16_tone_gen #(
        .CLK_HZ(1000), .TICK_HZ(100), .PRESCALE(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .din(din), .write_en(write_en),
        .dout(dout), .sound(sound), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];
    int   checkCount = 0;
    int   passCount  = 0;

    int nN;
    int nP[8], nD[8];
    int pushE[8], popE[8];
    bit acc[8];
    int dropEdge, lastJ, endC;

    task automatic expectAt(input int due, input int kind, input logic [15:0] val);
        exp_t e;
        int idx;
        e.due = due; e.kind = kind; e.val = val;
        idx = sbq.size();
        while (idx > 0 && sbq[idx-1].due > due) idx--;
        sbq.insert(idx, e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [15:0] act;
        string nm;
        case (e.kind)
            0:       begin act = {15'd0, sound}; nm = "sound"; end
            1:       begin act = {15'd0, busy};  nm = "busy";  end
            default: begin act = dout;           nm = "dout";  end
        endcase
        checkCount++;
        if (act === e.val) passCount++;
        else $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, e.val);
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) checkOutput(sbq.pop_front());
    end

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timeline model: note j is popped at edge popE[j], loads for one cycle,
    // then plays 10*D cycles; the next pop follows directly if a note is queued.
    task automatic buildModel();
        int e, cnt;
        bit popNow;
        lastJ = -1;
        dropEdge = 1 << 30;
        for (int i = 0; i < nN; i++) begin
            e = 2 * i + 1;
            pushE[i] = e;
            cnt = 0;
            popNow = 0;
            for (int j = 0; j < i; j++) begin
                if (acc[j]) begin
                    if (pushE[j] < e) cnt++;
                    if (popE[j] < e) cnt--;
                    if (popE[j] == e) popNow = 1;
                end
            end
            acc[i] = (cnt < 4) || popNow;
            if (acc[i]) begin
                popE[i] = (lastJ < 0) ? e + 1 : maxi(popE[lastJ] + 1 + TICK_DIV * nD[lastJ], e + 1);
                lastJ = i;
            end else begin
                popE[i] = 0;
                if (dropEdge > e) dropEdge = e;
            end
        end
        endC = popE[lastJ] + 1 + TICK_DIV * nD[lastJ];
    endtask

    function automatic bit inPlay(input int c, input int j);
        return acc[j] && c >= popE[j] + 1 && c <= popE[j] + TICK_DIV * nD[j];
    endfunction

    function automatic logic expSound(input int c);
        int k;
        for (int j = 0; j < nN; j++) begin
            if (inPlay(c, j)) begin
                k = c - popE[j] - 1;
                return (nP[j] != 0) && (((k / (PRESC * nP[j])) % 2) == 0);
            end
        end
        return 1'b0;
    endfunction

    function automatic int expCount(input int c);
        int n = 0;
        for (int j = 0; j < nN; j++) if (acc[j] && pushE[j] <= c && c < popE[j]) n++;
        return n;
    endfunction

    function automatic logic expPlaying(input int c);
        for (int j = 0; j < nN; j++) if (inPlay(c, j)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic expBusy(input int c);
        for (int j = 0; j < nN; j++)
            if (acc[j] && c >= popE[j] && c <= popE[j] + TICK_DIV * nD[j]) return 1'b1;
        return expCount(c) != 0;
    endfunction

    function automatic logic [15:0] expStatus(input int c);
        int n = expCount(c);
        return {8'h00, 4'(n), dropEdge <= c, n == 4, n == 0, expPlaying(c)};
    endfunction

    task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
        addr = a; din = d; write_en = 1'b1;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    // Stages and pushes nN notes back-to-back, then watches status on addr 2.
    task automatic applyStimulus();
        int base;
        base = cyc + 1;
        buildModel();
        for (int c = 0; c <= endC + 1; c++) begin
            expectAt(base + c, 0, {15'd0, expSound(c)});
            expectAt(base + c, 1, {15'd0, expBusy(c)});
        end
        for (int c = 2 * nN; c <= endC + 1; c++) expectAt(base + c, 2, expStatus(c - 1));
        for (int i = 0; i < nN; i++) begin
            writeReg(2'd0, 16'(nP[i]));
            writeReg(2'd1, 16'(nD[i]));
        end
        addr = 2'd2;
        while (cyc < base + endC + 2) @(negedge clk);
        writeReg(2'd2, 16'h0002);
        expectAt(cyc + 1, 2, 16'h0002);
        @(negedge clk);
    endtask

    task automatic setNotes(input int n, input int p0, input int d0, input int p1, input int d1,
                            input int p2, input int d2);
        nN = n;
        nP[0] = p0; nD[0] = d0; nP[1] = p1; nD[1] = d1; nP[2] = p2; nD[2] = d2;
    endtask

    initial begin
        int base;
        reset = 1'b1; write_en = 1'b0; addr = 2'd0; din = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        expectAt(cyc + 1, 0, 16'd0);
        expectAt(cyc + 1, 1, 16'd0);
        expectAt(cyc + 1, 2, 16'd0);
        @(negedge clk);
        addr = 2'd3;
        expectAt(cyc + 1, 2, 16'h70E5);
        @(negedge clk);
        writeReg(2'd3, 16'h1234);
        addr = 2'd3;
        expectAt(cyc + 1, 2, 16'h70E5);
        @(negedge clk);
        writeReg(2'd0, 16'h1234);
        addr = 2'd0;
        expectAt(cyc + 1, 2, 16'h1234);
        @(negedge clk);

        setNotes(1, 3, 2, 0, 0, 0, 0);
        applyStimulus();

        for (int n = 5; n <= 6; n++) begin
            nN = n;
            for (int i = 0; i < n; i++) begin nP[i] = i % 3 + 1; nD[i] = 1; end
            applyStimulus();
        end

        setNotes(3, 0, 1, 2, 0, 1, 1);
        applyStimulus();

        for (int b = 0; b < 6; b++) begin
            nN = int'($urandom_range(1, 6));
            for (int i = 0; i < nN; i++) begin
                nP[i] = int'($urandom_range(0, 4));
                nD[i] = int'($urandom_range(0, 3));
            end
            applyStimulus();
        end

        // Flush mid-note with a second note still queued.
        base = cyc + 1;
        expectAt(base + 3, 0, 16'd1);
        expectAt(base + 8, 0, 16'd1);
        expectAt(base + 8, 1, 16'd1);
        expectAt(base + 9, 0, 16'd0);
        expectAt(base + 9, 1, 16'd0);
        expectAt(base + 10, 2, 16'h0002);
        writeReg(2'd0, 16'd3); writeReg(2'd1, 16'd5);
        writeReg(2'd0, 16'd3); writeReg(2'd1, 16'd5);
        while (cyc < base + 8) @(negedge clk);
        writeReg(2'd2, 16'h0001);
        repeat (3) @(negedge clk);

        // Asynchronous reset between edges during a note.
        base = cyc + 1;
        expectAt(base + 3, 0, 16'd1);
        expectAt(base + 3, 1, 16'd1);
        writeReg(2'd0, 16'd2); writeReg(2'd1, 16'd3);
        while (cyc < base + 3) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        expectAt(cyc, 0, 16'd0);
        expectAt(cyc, 1, 16'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        addr = 2'd2;
        expectAt(cyc + 1, 2, 16'h0002);
        @(negedge clk);

        for (int t = 0; t < 50 && sbq.size() > 0; t++) @(negedge clk);
        if (sbq.size() > 0) begin
            checkCount += sbq.size();
            $display("[TB] FAIL pending: %0d expectations never checked, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
